wb_lsu_master: RTL and testbench

Wishbone bus master that turns single CPU load/store requests into classic single-cycle Wishbone transactions. It sits between the core's memory stage and the shared `wb_bus`, initiating cycles toward slaves such as the data memory. It handles lane steering (byte/half/word), sign/zero extension, misalignment detection, bus error and a watchdog timeout. Every issued address is word-aligned, because slaves reject addresses with `addr[1:0] != 0`.

---
 rtl/lsu_pkg.sv | 32 +++
 rtl/wb_bus.sv | 39 +++
 rtl/lsu_lane_align.sv | 43 ++++
 rtl/wb_lsu_master.sv | 121 ++++++++++++
 tb/tb_wb_lsu_master.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the Wishbone load/store master.
// Imported by the lane aligner, the top level and the bench.
package lsu_pkg;

  typedef enum logic [1:0] {
    SizeByte    = 2'b00,
    SizeHalf    = 2'b01,
    SizeWord    = 2'b10,
    SizeWordAlt = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBus  = 2'b01,
    StResp = 2'b10
  } lsu_state_t;

  localparam logic [3:0] LANE_BYTE = 4'b0001;
  localparam logic [3:0] LANE_HALF = 4'b0011;

  // The reserved size encoding behaves exactly like a word access.
  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SizeByte: mis = 1'b0;
      SizeHalf: mis = addr_lo[0];
      default:  mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/wb_bus.sv
// Classic Wishbone bus bundle shared by the masters and slaves of the system.
// The master modport drives the request side and samples the slave response.
interface wb_bus;

  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        err;

  modport master (
    output cyc,
    output stb,
    output we,
    output addr,
    output sel,
    output wdata,
    input  rdata,
    input  ack,
    input  err
  );

  modport slave (
    input  cyc,
    input  stb,
    input  we,
    input  addr,
    input  sel,
    input  wdata,
    output rdata,
    output ack,
    output err
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for stores and lane extraction plus sign/zero extension for loads.
// Purely combinational; the caller guarantees the access is naturally aligned.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  mem_size_t   size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic        is_unsigned,
  output logic [3:0]  sel,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    rd_byte = 8'(rdata >> {addr_lo, 3'b000});
    rd_half = 16'(rdata >> {addr_lo[1], 4'b0000});
  end

  always_comb begin
    sel       = 4'b1111;
    wdata_rep = wdata;
    rdata_ext = rdata;
    case (size)
      SizeByte: begin
        sel       = LANE_BYTE << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = is_unsigned ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      end
      SizeHalf: begin
        sel       = LANE_HALF << addr_lo;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = is_unsigned ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_lsu_master.sv
// Wishbone master turning single CPU load/store requests into classic bus cycles,
// with misalignment detection, bus-error forwarding and a wait-state watchdog.
module wb_lsu_master
  import lsu_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  mem_size_t   req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  wb_bus.master       bus_master
);

  localparam logic [7:0] TimeoutLimit = 8'(TimeoutCycles);

  lsu_state_t  state_q;
  logic        we_q;
  logic        unsigned_q;
  logic        err_q;
  mem_size_t   size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [7:0]  cnt_q;

  logic        in_bus;
  logic [3:0]  lane_sel;
  logic [31:0] lane_wdata;
  logic [31:0] load_ext;

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      unsigned_q <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= SizeByte;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q       <= req_we;
            unsigned_q <= req_unsigned;
            size_q     <= req_size;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            rdata_q    <= '0;
            cnt_q      <= '0;
            // Misaligned requests never touch the bus.
            if (is_misaligned(req_size, req_addr[1:0])) begin
              err_q   <= 1'b1;
              state_q <= StResp;
            end else begin
              err_q   <= 1'b0;
              state_q <= StBus;
            end
          end
        end
        StBus: begin
          if (bus_master.err) begin
            err_q   <= 1'b1;
            state_q <= StResp;
          end else if (bus_master.ack) begin
            rdata_q <= bus_master.rdata;
            state_q <= StResp;
          end else if (cnt_q == TimeoutLimit) begin
            err_q   <= 1'b1;
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  lsu_lane_align u_lane_align (
    .size        (size_q),
    .addr_lo     (addr_q[1:0]),
    .wdata       (wdata_q),
    .rdata       (rdata_q),
    .is_unsigned (unsigned_q),
    .sel         (lane_sel),
    .wdata_rep   (lane_wdata),
    .rdata_ext   (load_ext)
  );

  assign in_bus     = (state_q == StBus);
  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = (resp_valid && !err_q && !we_q) ? load_ext : '0;

  // Bus signals are quiet outside BUS so a late-committing slave sees nothing stale.
  assign bus_master.cyc   = in_bus;
  assign bus_master.stb   = in_bus;
  assign bus_master.we    = in_bus & we_q;
  assign bus_master.addr  = in_bus ? {addr_q[31:2], 2'b00} : '0;
  assign bus_master.sel   = in_bus ? lane_sel : 4'b0000;
  assign bus_master.wdata = in_bus ? lane_wdata : '0;

endmodule

// File: tb/tb_wb_lsu_master.sv
// Directed bench for wb_lsu_master against a one-wait-state memory slave model,
// with a response scoreboard and bus-activity counters.
module tb_wb_lsu_master;
  import lsu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  mem_size_t   req_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  wb_bus bus ();

  wb_lsu_master #(
    .TimeoutCycles (4)
  ) dut (
    .clk_in       (clk),
    .reset_in     (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .bus_master   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory slave: 0x3000-0x30FF acks after one wait state, 0x5xxx and unaligned
  // addresses return err, everything else never answers.
  logic        s_ack_q;
  logic        s_err_q;
  logic [31:0] s_rd_q;
  logic [31:0] mem [0:63];
  logic        s_req;
  logic        s_mapped;
  logic        s_errmap;

  assign s_req    = bus.cyc & bus.stb & ~s_ack_q & ~s_err_q;
  assign s_mapped = (bus.addr[31:8] == 24'h000030) && (bus.addr[1:0] == 2'b00);
  assign s_errmap = (bus.addr[15:12] == 4'h5) || (bus.addr[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_ack_q <= 1'b0;
      s_err_q <= 1'b0;
      s_rd_q  <= '0;
    end else begin
      s_ack_q <= s_req & s_mapped;
      s_err_q <= s_req & s_errmap;
      s_rd_q  <= mem[bus.addr[7:2]];
      if (s_ack_q && bus.we) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.sel[b]) mem[bus.addr[7:2]][8*b +: 8] <= bus.wdata[8*b +: 8];
        end
      end
    end
  end

  assign bus.ack   = s_ack_q;
  assign bus.err   = s_err_q;
  assign bus.rdata = s_rd_q;

  int          total = 0;
  int          bad = 0;
  logic [31:0] sb_d[$];
  logic        sb_e[$];
  int          cyc_cnt = 0;
  int          hs_cnt = 0;
  int          last_resp = 0;
  int          resp_count = 0;
  int          rises = 0;
  int          cyc_high = 0;
  logic        cyc_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc_cnt++;
  end

  // Response monitor: every resp_valid pulse must match the oldest expectation.
  initial forever begin
    logic [31:0] ed;
    logic        ee;
    @(negedge clk);
    if (bus.cyc && !cyc_prev) rises++;
    if (bus.cyc) cyc_high++;
    cyc_prev = bus.cyc;
    if (resp_valid) begin
      resp_count++;
      last_resp = cyc_cnt;
      chk("resp_expected", 32'(sb_d.size() != 0), 32'd1);
      if (sb_d.size() != 0) begin
        ed = sb_d.pop_front();
        ee = sb_e.pop_front();
        chk("resp_rdata", resp_rdata, ed);
        chk("resp_err", 32'(resp_err), 32'(ee));
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input mem_size_t sz, input logic uns, input logic [31:0] exp_d,
                       input logic exp_e, input bit push, input bit hold);
    int n;
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = a;
    req_wdata    = d;
    req_size     = sz;
    req_unsigned = uns;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
    if (push) begin
      sb_d.push_back(exp_d);
      sb_e.push_back(exp_e);
    end
    hs_cnt = cyc_cnt + 1;
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb_d.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain"}, 32'(sb_d.size()), 32'd0);
    @(negedge clk);
  endtask

  int r0;
  int c0;
  int h0;

  initial begin
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    req_size     = SizeWord;
    req_unsigned = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_cyc", 32'(bus.cyc), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);

    // Byte store, then word load.
    issue(1'b1, 32'h3004, 32'h0, SizeWord, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    drain("clear_word");
    issue(1'b1, 32'h3005, 32'hAB, SizeByte, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("sb_cyc", 32'(bus.cyc), 32'd1);
    chk("sb_we", 32'(bus.we), 32'd1);
    chk("sb_addr", bus.addr, 32'h3004);
    chk("sb_sel", 32'(bus.sel), 32'h2);
    chk("sb_wdata", bus.wdata, 32'hABABABAB);
    drain("byte_store");
    chk("idle_addr", bus.addr, 32'h0);
    chk("idle_sel", 32'(bus.sel), 32'h0);
    chk("idle_wdata", bus.wdata, 32'h0);
    issue(1'b0, 32'h3004, 32'h0, SizeWord, 1'b0, 32'h0000AB00, 1'b0, 1'b1, 1'b0);
    drain("word_load");
    chk("load_latency", 32'(last_resp - hs_cnt + 1), 32'd3);

    // Sign/zero extension.
    issue(1'b1, 32'h3000, 32'h80FF8000, SizeWord, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 32'h3001, 32'h0, SizeByte, 1'b0, 32'hFFFFFF80, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 32'h3002, 32'h0, SizeHalf, 1'b1, 32'h000080FF, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 32'h3002, 32'h0, SizeHalf, 1'b0, 32'hFFFF80FF, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 32'h3003, 32'h0, SizeByte, 1'b1, 32'h00000080, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 32'h3000, 32'h0, SizeWordAlt, 1'b0, 32'h80FF8000, 1'b0, 1'b1, 1'b0);
    drain("extend");

    // Misaligned accesses: immediate error, no bus cycle, memory untouched.
    r0 = rises;
    issue(1'b0, 32'h3003, 32'h0, SizeHalf, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    drain("mis_half");
    chk("mis_latency", 32'(last_resp - hs_cnt + 1), 32'd1);
    issue(1'b1, 32'h3002, 32'h12345678, SizeWord, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    drain("mis_word");
    chk("mis_no_cyc", 32'(rises - r0), 32'd0);
    issue(1'b0, 32'h3000, 32'h0, SizeWord, 1'b0, 32'h80FF8000, 1'b0, 1'b1, 1'b0);
    drain("mis_readback");

    // Slave error.
    issue(1'b0, 32'h5000, 32'h0, SizeWord, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    drain("bus_err");
    chk("err_latency", 32'(last_resp - hs_cnt + 1), 32'd3);

    // Unmapped address: watchdog fires after TimeoutCycles + 1 bus cycles.
    h0 = cyc_high;
    issue(1'b0, 32'h8000, 32'h0, SizeWord, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    drain("timeout");
    chk("timeout_cyc_cycles", 32'(cyc_high - h0), 32'd5);
    chk("timeout_latency", 32'(last_resp - hs_cnt + 1), 32'd6);
    chk("timeout_cyc_low", 32'(bus.cyc), 32'd0);

    // Back-to-back stores with req_valid held high.
    r0 = rises;
    c0 = resp_count;
    issue(1'b1, 32'h3008, 32'h11223344, SizeWord, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    issue(1'b1, 32'h300C, 32'h55667788, SizeWord, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    drain("b2b");
    chk("b2b_bus_cycles", 32'(rises - r0), 32'd2);
    chk("b2b_resp_count", 32'(resp_count - c0), 32'd2);
    issue(1'b0, 32'h3008, 32'h0, SizeWord, 1'b0, 32'h11223344, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 32'h300C, 32'h0, SizeWord, 1'b0, 32'h55667788, 1'b0, 1'b1, 1'b0);
    drain("b2b_readback");

    // Upper half store.
    issue(1'b1, 32'h300E, 32'h0000BEEF, SizeHalf, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("hs_addr", bus.addr, 32'h300C);
    chk("hs_sel", 32'(bus.sel), 32'hC);
    chk("hs_wdata", bus.wdata, 32'hBEEFBEEF);
    drain("half_store");
    issue(1'b0, 32'h300C, 32'h0, SizeWord, 1'b0, 32'hBEEF7788, 1'b0, 1'b1, 1'b0);
    drain("half_readback");

    // Reset in the middle of a bus cycle: no response, clean restart.
    c0 = resp_count;
    issue(1'b0, 32'h3000, 32'h0, SizeWord, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("mid_cyc_high", 32'(bus.cyc), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_cyc", 32'(bus.cyc), 32'd0);
    chk("mid_rst_resp", 32'(resp_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    repeat (6) @(negedge clk);
    chk("mid_rst_no_resp", 32'(resp_count - c0), 32'd0);
    issue(1'b0, 32'h3000, 32'h0, SizeWord, 1'b0, 32'h80FF8000, 1'b0, 1'b1, 1'b0);
    drain("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
